// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of write-back request, issue-stage hazard query and register file write signals.
// The bypass outputs exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    // Handshake: a requester raises *_valid with stable dest/data and holds them
    // until it sees *_ready high in the same cycle; valid&ready is the transfer.
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_dest;
    logic [DATA_W-1:0] lsu_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic              flush;
    logic [ADDR_W-1:0] src1_idx;
    logic [ADDR_W-1:0] src2_idx;
    logic              src1_busy;
    logic              src2_busy;
    logic              dest_busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
`ifdef REGFILE_WB_BYPASS_EN
    logic              src1_byp_en;
    logic              src2_byp_en;
    logic [DATA_W-1:0] src1_byp_data;
    logic [DATA_W-1:0] src2_byp_data;

    modport slave (
        input  alu_valid, alu_dest, alu_data, lsu_valid, lsu_dest, lsu_data,
        input  issue_valid, issue_dest, flush, src1_idx, src2_idx,
        output alu_ready, lsu_ready, src1_busy, src2_busy, dest_busy,
        output rf_we, rf_waddr, rf_wdata,
        output src1_byp_en, src2_byp_en, src1_byp_data, src2_byp_data
    );
    modport master (
        output alu_valid, alu_dest, alu_data, lsu_valid, lsu_dest, lsu_data,
        output issue_valid, issue_dest, flush, src1_idx, src2_idx,
        input  alu_ready, lsu_ready, src1_busy, src2_busy, dest_busy,
        input  rf_we, rf_waddr, rf_wdata,
        input  src1_byp_en, src2_byp_en, src1_byp_data, src2_byp_data
    );
`else
    modport slave (
        input  alu_valid, alu_dest, alu_data, lsu_valid, lsu_dest, lsu_data,
        input  issue_valid, issue_dest, flush, src1_idx, src2_idx,
        output alu_ready, lsu_ready, src1_busy, src2_busy, dest_busy,
        output rf_we, rf_waddr, rf_wdata
    );
    modport master (
        output alu_valid, alu_dest, alu_data, lsu_valid, lsu_dest, lsu_data,
        output issue_valid, issue_dest, flush, src1_idx, src2_idx,
        input  alu_ready, lsu_ready, src1_busy, src2_busy, dest_busy,
        input  rf_we, rf_waddr, rf_wdata
    );
`endif
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register file write port (ALU vs load) plus pending-write scoreboard.
// Optional same-cycle write bypass to the issue stage is enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_wb_scheduler_if.slave  bus
);
    logic              rr_last_lsu;
    logic              grant_alu;
    logic              grant_lsu;
    logic              accept;
    logic              wr_real;
    logic [ADDR_W-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              byp1;
    logic              byp2;

    // Ties go to whoever was not granted last; a lone requester always wins.
    always_comb begin
        grant_alu = bus.alu_valid && (!bus.lsu_valid || rr_last_lsu);
        grant_lsu = bus.lsu_valid && !grant_alu;
        accept    = grant_alu || grant_lsu;
        sel_dest  = grant_lsu ? bus.lsu_dest : bus.alu_dest;
        sel_data  = grant_lsu ? bus.lsu_data : bus.alu_data;
        wr_real   = accept && (sel_dest != '0);
    end

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rr_last_lsu <= 1'b1;
            pending     <= '0;
        end else begin
            rf_we <= wr_real;
            if (wr_real) begin
                rf_waddr <= sel_dest;
                rf_wdata <= sel_data;
            end
            if (accept) begin
                rr_last_lsu <= grant_lsu;
            end
            pending <= pending_nxt;
        end
    end

    // Order matters: retire clear, then issue set (set wins), then flush over everything.
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_waddr] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_dest != '0)) begin
            pending_nxt[bus.issue_dest] = 1'b1;
        end
        if (bus.flush) begin
            pending_nxt = '0;
        end
        pending_nxt[0] = 1'b0;
    end

    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp1 = rf_we && (rf_waddr == bus.src1_idx) && (bus.src1_idx != '0);
    assign byp2 = rf_we && (rf_waddr == bus.src2_idx) && (bus.src2_idx != '0);
    assign bus.src1_byp_en   = byp1;
    assign bus.src2_byp_en   = byp2;
    assign bus.src1_byp_data = rf_wdata;
    assign bus.src2_byp_data = rf_wdata;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign bus.src1_busy = pending[bus.src1_idx] && !byp1;
    assign bus.src2_busy = pending[bus.src2_idx] && !byp2;
    assign bus.dest_busy = pending[bus.issue_dest];
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected register file writes go into a queue
// and a negedge monitor pops and compares them whenever rf_we is seen.
module tb_regfile_wb_scheduler;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int QW     = 16 + ADDR_W + DATA_W;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic [QW-1:0] exp_q[$];

    regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.lsu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_wb(input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                            input logic lv, input logic [ADDR_W-1:0] ld, input logic [DATA_W-1:0] ldat,
                            input logic ea, input logic el);
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adat;
        bus.lsu_valid = lv;
        bus.lsu_dest  = ld;
        bus.lsu_data  = ldat;
        #1;
        check("alu_ready", 64'(bus.alu_ready), 64'(ea));
        check("lsu_ready", 64'(bus.lsu_ready), 64'(el));
        if (ea && ad != '0) exp_q.push_back({16'(cyc + 1), ad, adat});
        if (el && ld != '0) exp_q.push_back({16'(cyc + 1), ld, ldat});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [QW-1:0] e;
        if (rst_n) begin
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_write: got rf_we=1 addr %0h expected rf_we=0 (cycle %0d)",
                             bus.rf_waddr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_cycle", 64'(cyc), 64'(e[QW-1 -: 16]));
                    check("wb_addr", 64'(bus.rf_waddr), 64'(e[DATA_W +: ADDR_W]));
                    check("wb_data", 64'(bus.rf_wdata), 64'(e[DATA_W-1:0]));
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][QW-1 -: 16]) <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_write: got rf_we=0 expected write addr %0h in cycle %0d",
                         e[DATA_W +: ADDR_W], cyc);
            end
        end
    end

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        bus.alu_dest   = '0;
        bus.alu_data   = '0;
        bus.lsu_dest   = '0;
        bus.lsu_data   = '0;
        bus.issue_dest = '0;
        bus.src1_idx   = '0;
        bus.src2_idx   = '0;
        do_reset();

        // reset state
        #1;
        check("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_ready", 64'({bus.alu_ready, bus.lsu_ready}), 64'd0);
        step();

        // single ALU write, one-cycle latency, then idle
        drive_wb(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0, 1, 0);
        step();
        step();
        #1;
        check("idle_rf_we", 64'(bus.rf_we), 64'd0);
        check("hold_waddr", 64'(bus.rf_waddr), 64'd3);
        check("hold_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);

        // both valid continuously after reset: ALU, LSU, ALU, LSU back to back
        do_reset();
        drive_wb(1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 1, 0);
        step();
        drive_wb(1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 0, 1);
        step();
        drive_wb(1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 1, 0);
        step();
        drive_wb(1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 0, 1);
        step();
        step();

        // RAW tracking on r5 with a load write-back
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 4'd5;
        bus.src1_idx    = 4'd5;
        #1;
        check("dest_busy_r5_pre", 64'(bus.dest_busy), 64'd0);
        step();
        #1;
        check("src1_busy_r5_set", 64'(bus.src1_busy), 64'd1);
        drive_wb(0, 4'd0, 32'h0, 1, 4'd5, 32'hCAFE0005, 0, 1);
        step();
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        check("src1_busy_r5_byp", 64'(bus.src1_busy), 64'd0);
        check("src1_byp_en", 64'(bus.src1_byp_en), 64'd1);
        check("src1_byp_data", 64'(bus.src1_byp_data), 64'hCAFE0005);
`else
        check("src1_busy_r5_wb", 64'(bus.src1_busy), 64'd1);
`endif
        step();
        #1;
        check("src1_busy_r5_clr", 64'(bus.src1_busy), 64'd0);

        // same-edge clear and set of r7: set wins
        drive_wb(1, 4'd7, 32'h77, 0, 4'd0, 32'h0, 1, 0);
        step();
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 4'd7;
        #1;
        check("dest_busy_r7_pre", 64'(bus.dest_busy), 64'd0);
        step();
        bus.issue_dest = 4'd7;
        #1;
        check("dest_busy_r7_set", 64'(bus.dest_busy), 64'd1);

        // register 0: accepted but never written, never pending
        drive_wb(1, 4'd0, 32'h55, 0, 4'd0, 32'h0, 1, 0);
        step();
        #1;
        check("r0_rf_we", 64'(bus.rf_we), 64'd0);
        check("r0_hold_waddr", 64'(bus.rf_waddr), 64'd7);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 4'd0;
        #1;
        check("r0_dest_busy_now", 64'(bus.dest_busy), 64'd0);
        step();
        bus.issue_dest = 4'd0;
        bus.src1_idx   = 4'd0;
        #1;
        check("r0_dest_busy_next", 64'(bus.dest_busy), 64'd0);
        check("r0_src1_busy", 64'(bus.src1_busy), 64'd0);

        // pending r2, r4, r9 then flush with a competing issue of r4
        bus.issue_valid = 1'b1; bus.issue_dest = 4'd2; step();
        bus.issue_valid = 1'b1; bus.issue_dest = 4'd4; step();
        bus.issue_valid = 1'b1; bus.issue_dest = 4'd9; step();
        bus.src1_idx   = 4'd2;
        bus.src2_idx   = 4'd9;
        bus.issue_dest = 4'd4;
        #1;
        check("pend_r2", 64'(bus.src1_busy), 64'd1);
        check("pend_r9", 64'(bus.src2_busy), 64'd1);
        check("pend_r4", 64'(bus.dest_busy), 64'd1);
        bus.flush       = 1'b1;
        bus.issue_valid = 1'b1;
        step();
        bus.issue_dest = 4'd4;
        #1;
        check("flush_r2", 64'(bus.src1_busy), 64'd0);
        check("flush_r9", 64'(bus.src2_busy), 64'd0);
        check("flush_r4", 64'(bus.dest_busy), 64'd0);
        bus.src1_idx = 4'd7;
        #1;
        check("flush_r7", 64'(bus.src1_busy), 64'd0);

        // reset asserted during an rf_we cycle
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 4'd6;
        step();
        drive_wb(1, 4'd6, 32'h66, 0, 4'd0, 32'h0, 1, 0);
        step();
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        bus.src1_idx = 4'd6;
        #1;
        check("rst_mid_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_mid_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_mid_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_mid_busy_r6", 64'(bus.src1_busy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
